// File: rtl/monitor_overlay_pkg.sv
// Shared definitions for monitor_overlay: overlay FSM encoding and 6502 bus constants.
package monitor_overlay_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_OVERLAY = 2'd2,
    ST_EXIT    = 2'd3
  } ovl_state_t;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;
  localparam logic [7:0]  OP_RTI    = 8'h40;
  localparam logic [7:0]  PAGE_TOP  = 8'hFF;

endpackage

// File: rtl/monitor_overlay_bus_cycle_sync.sv
// Two-flop synchroniser with a one-clk edge pulse per bit.
// RISE=1 pulses on the synchronised rising edge, RISE=0 on the falling edge.
module bus_cycle_sync #(
  parameter int W    = 1,
  parameter bit RISE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_edge
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;
  logic [W-1:0] r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  generate
    if (RISE) begin : g_rise
      assign o_edge = r_sync & ~r_prev;
    end else begin : g_fall
      assign o_edge = ~r_sync & r_prev;
    end
  endgenerate

endmodule

// File: rtl/monitor_overlay.sv
// Maps the 6502 top page onto the monitor ROM from NMI vector fetch until RTI returns.
// Optional MONITOR_OVERLAY_ENTRY_COUNT_EN adds a saturating ovl_entries counter.
module monitor_overlay
  import monitor_overlay_pkg::*;
#(
  parameter logic [7:0]  OVL_PAGE    = PAGE_TOP,
  parameter logic [15:0] NMI_VEC_LO  = VEC_NMI,
  parameter int          ARM_TIMEOUT = 64,
  parameter logic [7:0]  RTI_OPCODE  = OP_RTI
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phi2,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        cpu_sync,
  input  logic [7:0]  cpu_data,
  input  logic        nmi_n,
  output logic        ovl_sel,
  output logic [7:0]  mon_addr,
  output logic [1:0]  ovl_state,
`ifdef MONITOR_OVERLAY_ENTRY_COUNT_EN
  output logic [7:0]  ovl_entries,
`endif
  output logic        arm_timeout
);

  localparam int            CW       = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ARM_TIMEOUT - 1);

  ovl_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_nmi_pend;
  logic          r_arm_timeout;

  logic w_cyc;
  logic w_nmi_fall;
  logic w_page_rd;
  logic w_vec_rd;
  logic w_vec_pair;
  logic w_enter;
  logic w_rti_fetch;

  bus_cycle_sync #(.W(1), .RISE(1'b1)) u_phi2_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (phi2),
    .o_edge  (w_cyc)
  );

  bus_cycle_sync #(.W(1), .RISE(1'b0)) u_nmi_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (nmi_n),
    .o_edge  (w_nmi_fall)
  );

  // The bus is stable at the synchronised phi2 rise, so cyc decisions use it directly.
  assign w_page_rd   = cpu_rw && (cpu_addr[15:8] == OVL_PAGE);
  assign w_vec_rd    = cpu_rw && (cpu_addr == NMI_VEC_LO);
  assign w_vec_pair  = (cpu_addr == NMI_VEC_LO) || (cpu_addr == NMI_VEC_LO + 16'd1);
  assign w_enter     = w_cyc && (r_state == ST_ARMED) && w_vec_rd;
  assign w_rti_fetch = cpu_sync && w_page_rd && (cpu_data == RTI_OPCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_NORMAL;
      r_cnt         <= '0;
      r_nmi_pend    <= 1'b0;
      r_arm_timeout <= 1'b0;
    end else begin
      // A fall arriving while the pending NMI is consumed re-arms it for the next pass.
      r_nmi_pend <= w_nmi_fall || (r_nmi_pend && (r_state != ST_NORMAL));
      case (r_state)
        ST_NORMAL: begin
          if (r_nmi_pend) begin
            r_state <= ST_ARMED;
            r_cnt   <= '0;
          end
        end
        ST_ARMED: begin
          if (w_enter) begin
            r_state <= ST_OVERLAY;
          end else if (w_cyc) begin
            if (r_cnt == CNT_LAST) begin
              r_state       <= ST_NORMAL;
              r_arm_timeout <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_OVERLAY: begin
          if (w_cyc && w_rti_fetch) r_state <= ST_EXIT;
        end
        ST_EXIT: begin
          if (w_cyc && cpu_sync) r_state <= ST_NORMAL;
        end
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

`ifdef MONITOR_OVERLAY_ENTRY_COUNT_EN
  logic [7:0] r_entries;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entries <= 8'd0;
    end else if (w_enter && (r_entries != 8'hFF)) begin
      r_entries <= r_entries + 8'd1;
    end
  end

  assign ovl_entries = r_entries;
`endif

  // The return fetch after RTI is a sync cycle in EXIT, so it is never overlaid.
  assign ovl_sel = w_page_rd && ((r_state == ST_OVERLAY) ||
                                 ((r_state == ST_ARMED) && w_vec_pair) ||
                                 ((r_state == ST_EXIT) && !cpu_sync));

  assign mon_addr    = cpu_addr[7:0];
  assign ovl_state   = r_state;
  assign arm_timeout = r_arm_timeout;

endmodule
